pipeline_issue_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_result_fifo.sv | 45 ++++
 rtl/pipeline_issue_ctrl.sv | 94 +++++++++
 tb/tb_pipeline_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults, clog2 helper and operand quadruple type
package pipe_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_LAT   = 2;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a1;
        logic [DEF_WIDTH-1:0] a2;
        logic [DEF_WIDTH-1:0] b1;
        logic [DEF_WIDTH-1:0] b2;
    } quad_t;
endpackage

// File: rtl/pipe_result_fifo.sv
// rtl/pipe_result_fifo.sv - synchronous result FIFO with occupancy count
module pipe_result_fifo import pipe_pkg::*; #(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/pipeline_issue_ctrl.sv
// rtl/pipeline_issue_ctrl.sv - issue/credit controller around a fixed-latency pipeline
// Optional PIPE_ISSUE_STATS_EN adds issue_cnt/stall_cnt counters.
module pipeline_issue_ctrl import pipe_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a1,
    input  logic [WIDTH-1:0] in_a2,
    input  logic [WIDTH-1:0] in_b1,
    input  logic [WIDTH-1:0] in_b2,
    output logic [WIDTH-1:0] pipe_a1,
    output logic [WIDTH-1:0] pipe_a2,
    output logic [WIDTH-1:0] pipe_b1,
    output logic [WIDTH-1:0] pipe_b2,
    input  logic [WIDTH-1:0] pipe_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             busy
`ifdef PIPE_ISSUE_STATS_EN
    ,
    output logic [31:0]      issue_cnt,
    output logic [31:0]      stall_cnt
`endif
);
    localparam int CW = clog2(DEPTH + 1);
    localparam int OW = clog2(DEPTH + LAT + 1);

    logic           issue;
    logic           pop;
    logic [LAT-1:0] vld_sr;
    logic [CW-1:0]  fifo_count;
    logic [OW-1:0]  occupancy;

    // Every in-flight slot already owns a FIFO entry, so the pipeline can never overrun it.
    always_comb begin
        occupancy = OW'(fifo_count);
        for (int i = 0; i < LAT; i++) occupancy = occupancy + OW'(vld_sr[i]);
    end

    assign in_ready  = !reset && (occupancy < OW'(DEPTH));
    assign issue     = in_valid & in_ready;
    assign pipe_a1   = issue ? in_a1 : '0;
    assign pipe_a2   = issue ? in_a2 : '0;
    assign pipe_b1   = issue ? in_b1 : '0;
    assign pipe_b2   = issue ? in_b2 : '0;
    assign out_valid = !reset && (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign busy      = !reset && (occupancy != '0);

    generate
        if (LAT == 1) begin : g_sr_one
            always_ff @(posedge clk) begin
                if (reset) vld_sr <= '0;
                else       vld_sr <= issue;
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk) begin
                if (reset) vld_sr <= '0;
                else       vld_sr <= {vld_sr[LAT-2:0], issue};
            end
        end
    endgenerate

    pipe_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vld_sr[LAT-1]),
        .wr_data (pipe_c),
        .rd_en   (pop),
        .rd_data (out_c),
        .count   (fifo_count)
    );

`ifdef PIPE_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue)                 issue_cnt <= issue_cnt + 32'd1;
            if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// tb/tb_pipeline_issue_ctrl.sv - self-checking bench for pipeline_issue_ctrl
module tb_pipeline_issue_ctrl;
    import pipe_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int NV    = 8;

    typedef struct packed {
        quad_t       q;
        logic [31:0] c;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a1, in_a2, in_b1, in_b2;
    logic [31:0] pipe_a1, pipe_a2, pipe_b1, pipe_b2;
    logic [31:0] pipe_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic        busy;
`ifdef PIPE_ISSUE_STATS_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ovf      = 0;
    logic [31:0] exp_q[$];
    vec_t        tbl [NV];
    logic [31:0] stg [LAT];

    pipeline_issue_ctrl #(
        .WIDTH (32),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a1     (in_a1),
        .in_a2     (in_a2),
        .in_b1     (in_b1),
        .in_b2     (in_b2),
        .pipe_a1   (pipe_a1),
        .pipe_a2   (pipe_a2),
        .pipe_b1   (pipe_b1),
        .pipe_b2   (pipe_b2),
        .pipe_c    (pipe_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
`ifdef PIPE_ISSUE_STATS_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model of the non-stallable arithmetic pipeline: LAT register stages.
    always @(posedge clk) begin
        stg[0] <= pipe_a1 * pipe_b1 + pipe_a2 * pipe_b2;
        for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
    assign pipe_c = stg[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("result_pending", 32'(exp_q.size()), 32'd1);
            else                   chk("out_c_order", out_c, exp_q.pop_front());
        end
        if (exp_q.size() > DEPTH) ovf++;
    end

    function automatic vec_t mk(input logic [31:0] a1, b1, a2, b2, c);
        vec_t v;
        v.q.a1 = a1; v.q.b1 = b1; v.q.a2 = a2; v.q.b2 = b2; v.c = c;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_a1 = v.q.a1; in_a2 = v.q.a2; in_b1 = v.q.b1; in_b2 = v.q.b2;
    endtask

    task automatic send(input vec_t v);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        drive(v);
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v.c);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("accept_in_time", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int seen;
        tbl[0] = mk(32'd0, 32'd1, 32'd2, 32'd3, 32'd6);
        tbl[1] = mk(32'd3, 32'd1, 32'd2, 32'd0, 32'd3);
        tbl[2] = mk(32'd5, 32'd7, 32'd1, 32'd1, 32'd36);
        tbl[3] = mk(32'd100, 32'd200, 32'd3, 32'd4, 32'd20012);
        tbl[4] = mk(32'hffffffff, 32'd2, 32'd1, 32'd1, 32'hffffffff);
        tbl[5] = mk(32'd7, 32'd0, 32'd0, 32'd9, 32'd0);
        tbl[6] = mk(32'd12, 32'd12, 32'd13, 32'd13, 32'd313);
        tbl[7] = mk(32'h10000, 32'h10000, 32'd1, 32'd1, 32'd1);

        // Reset state, with a request pending to prove gating.
        reset = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        in_a1 = 32'd5; in_a2 = 32'd5; in_b1 = 32'd5; in_b2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_pipe_a1", pipe_a1, 32'd0);
`ifdef PIPE_ISSUE_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Single issue: latency and busy fall.
        out_ready = 1'b1;
        in_valid = 1'b1;
        drive(tbl[0]);
        @(negedge clk);
        chk("single_pipe_a2", pipe_a2, 32'd2);
        chk("single_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(tbl[0].c);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        chk("lat_edge1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_edge2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge3_valid", 32'(out_valid), 32'd1);
        chk("single_out_c", out_c, 32'd6);
        @(negedge clk);
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_valid_fall", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Table of back-to-back issues with the consumer always ready.
        for (int i = 0; i < NV; i++) send(tbl[i]);
        in_valid = 1'b0;
        wait_idle("table_drain");

        // Simultaneous FIFO write and pop with two entries held.
        out_ready = 1'b0;
        send(tbl[2]); send(tbl[3]); send(tbl[4]);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("simul_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("simul_after_wp_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("simul_second_pop_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("simul_empty_valid", 32'(out_valid), 32'd0);
        chk("simul_empty_busy", 32'(busy), 32'd0);
        chk("simul_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Backpressure: credits run out after DEPTH accepts.
        out_ready = 1'b0;
        do_reset();
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            drive(tbl[idx % NV]);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(tbl[idx % NV].c);
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_accepts", 32'(idx), 32'(DEPTH));
        @(negedge clk);
        chk("full_no_bypass", 32'(in_ready), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
`ifdef PIPE_ISSUE_STATS_EN
        chk("bp_issue_cnt", issue_cnt, 32'd4);
        chk("bp_stall_cnt", stall_cnt, 32'd6);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        wait_idle("bp_drain");

        // Reset while two results are in flight.
        send(tbl[5]); send(tbl[6]);
        in_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("midrst_no_stale", 32'(seen), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);

        chk("no_overflow", 32'(ovf), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
